// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - requester and multiplier bundle for the mult_sched scheduler
interface mult_sched_if;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [63:0] result;
    logic        busy;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_prod;

    modport slave (
        input  req, a0, b0, a1, b1, mul_prod,
        output ack, done, result, busy, mul_a, mul_b
    );

    modport master (
        output req, a0, b0, a1, b1, mul_prod,
        input  ack, done, result, busy, mul_a, mul_b
    );
endinterface

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin scheduler sharing one 32x32->64 multiplier between two requesters
// Optional signed operation enabled by defining MULT_SCHED_SIGNED_EN.
module mult_sched #(
    parameter int MUL_LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    mult_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [63:0] result_q, result_d;
    logic [1:0]  done_q, done_d;
    logic        busy_q, busy_d;
`ifdef MULT_SCHED_SIGNED_EN
    logic        neg_q, neg_d;
`endif

    logic        gnt;
    logic [1:0]  ack_c;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

`ifdef MULT_SCHED_SIGNED_EN
    // Magnitude of a two's-complement word; -2^31 maps to 0x80000000 unsigned.
    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction
`endif

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        gnt   = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        ack_c = 2'b00;
        if (state_q == IDLE && bus.req != 2'b00) begin
            ack_c = gnt ? 2'b10 : 2'b01;
        end
        sel_a = gnt ? bus.a1 : bus.a0;
        sel_b = gnt ? bus.b1 : bus.b0;
    end

    // Next-state and datapath updates for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        done_d   = 2'b00;
`ifdef MULT_SCHED_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (ack_c != 2'b00) begin
`ifdef MULT_SCHED_SIGNED_EN
                    op_a_d = mag(sel_a);
                    op_b_d = mag(sel_b);
                    neg_d  = sel_a[31] ^ sel_b[31];
`else
                    op_a_d = sel_a;
                    op_b_d = sel_b;
`endif
                    owner_d = gnt;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
`ifdef MULT_SCHED_SIGNED_EN
                    result_d = neg_q ? (~bus.mul_prod + 64'd1) : bus.mul_prod;
`else
                    result_d = bus.mul_prod;
`endif
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register; reset aborts any operation and restores the tie pointer to requester 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            result_q <= 64'd0;
            done_q   <= 2'b00;
            busy_q   <= 1'b0;
`ifdef MULT_SCHED_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef MULT_SCHED_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign bus.ack    = ack_c;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.mul_a  = op_a_q;
    assign bus.mul_b  = op_b_q;

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - directed table-driven bench for mult_sched
module tb_mult_sched;

    localparam int MUL_LAT = 3;

    logic clk;
    logic reset;
    mult_sched_if intf ();

    mult_sched #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product appears MUL_LAT-1 edges after operands change,
    // so it is first correct in the last BUSY cycle and stale before that.
    logic [63:0] pipe0, pipe1;
    always @(posedge clk) begin
        pipe0 <= {32'd0, intf.mul_a} * {32'd0, intf.mul_b};
        pipe1 <= pipe0;
    end
    assign intf.mul_prod = pipe1;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        owner;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[8];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one request pattern in IDLE and follow it through to completion.
    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] exp_ack;
        logic       phase_ok;
        exp_ack   = v.owner ? 2'b10 : 2'b01;
        intf.req  = v.req;
        intf.a0   = v.a0;
        intf.b0   = v.b0;
        intf.a1   = v.a1;
        intf.b1   = v.b1;
        #1;
        check($sformatf("v%0d_ack", idx), {62'd0, intf.ack}, {62'd0, exp_ack});
        step();
        intf.req = v.req & ~exp_ack;
        phase_ok = 1'b1;
        for (int i = 0; i < MUL_LAT; i++) begin
            if (intf.busy !== 1'b1 || intf.done !== 2'b00 || intf.ack !== 2'b00) phase_ok = 1'b0;
            step();
        end
        check($sformatf("v%0d_busy_phase", idx), {63'd0, phase_ok}, 64'd1);
        check($sformatf("v%0d_done", idx), {62'd0, intf.done}, {62'd0, exp_ack});
        check($sformatf("v%0d_result", idx), intf.result, v.res);
        check($sformatf("v%0d_busy_in_done", idx), {63'd0, intf.busy}, 64'd1);
        step();
        check($sformatf("v%0d_idle", idx), {61'd0, intf.busy, intf.done}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 64'd42};
        vecs[1] = '{2'b10, 32'd0, 32'd0, 32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000};
        vecs[2] = '{2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd15};
`ifdef MULT_SCHED_SIGNED_EN
        vecs[3] = '{2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1};
        vecs[4] = '{2'b11, 32'hFFFF_FFFE, 32'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[7] = '{2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
`else
        vecs[3] = '{2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{2'b11, 32'hFFFF_FFFE, 32'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h0000_0002_FFFF_FFFA};
        vecs[7] = '{2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 64'h0000_0000_FFFF_FFFF};
`endif
        vecs[5] = '{2'b11, 32'hFFFF_FFFE, 32'd3, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[6] = '{2'b11, 32'd0, 32'd123, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'd0};

        intf.req = 2'b00;
        intf.a0  = 32'd0;
        intf.b0  = 32'd0;
        intf.a1  = 32'd0;
        intf.b1  = 32'd0;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;

        check("rst_ack", {62'd0, intf.ack}, 64'd0);
        check("rst_done", {62'd0, intf.done}, 64'd0);
        check("rst_busy", {63'd0, intf.busy}, 64'd0);
        check("rst_result", intf.result, 64'd0);
        check("rst_mul_ab", {intf.mul_a, intf.mul_b}, 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        intf.req = 2'b00;
        step();

        // Back-pressure: requester 1 waits through a whole operation; operands at its ack are used.
        intf.req = 2'b01;
        intf.a0  = 32'd9;
        intf.b0  = 32'd9;
        intf.a1  = 32'd1;
        intf.b1  = 32'd1;
        #1;
        check("bp_ack0", {62'd0, intf.ack}, 64'd1);
        step();
        intf.req = 2'b10;
        #1;
        check("bp_no_ack_busy", {62'd0, intf.ack}, 64'd0);
        check("bp_mul_a_stable", {32'd0, intf.mul_a}, 64'd9);
        step();
        step();
        intf.a1 = 32'd11;
        intf.b1 = 32'd13;
        check("bp_no_ack_late", {62'd0, intf.ack}, 64'd0);
        step();
        check("bp_done0", {62'd0, intf.done}, 64'd1);
        check("bp_result0", intf.result, 64'd81);
        check("bp_no_ack_done", {62'd0, intf.ack}, 64'd0);
        step();
        check("bp_ack1", {62'd0, intf.ack}, 64'd2);
        check("bp_mul_a_held", {32'd0, intf.mul_a}, 64'd9);
        step();
        intf.req = 2'b00;
        check("bp_mul_a_new", {32'd0, intf.mul_a}, 64'd11);
        step();
        step();
        step();
        check("bp_done1", {62'd0, intf.done}, 64'd2);
        check("bp_result1", intf.result, 64'd143);
        step();

        // Reset one cycle after ack: operation aborted, pointer back to 1.
        run_vec('{2'b01, 32'd2, 32'd2, 32'd0, 32'd0, 1'b0, 64'd4}, 8);
        intf.req = 2'b11;
        intf.a0  = 32'd5;
        intf.b0  = 32'd5;
        intf.a1  = 32'd6;
        intf.b1  = 32'd7;
        #1;
        check("mr_ack1", {62'd0, intf.ack}, 64'd2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mr_busy", {63'd0, intf.busy}, 64'd0);
        check("mr_done", {62'd0, intf.done}, 64'd0);
        check("mr_result", intf.result, 64'd0);
        run_vec('{2'b11, 32'd5, 32'd5, 32'd6, 32'd7, 1'b0, 64'd25}, 9);
        intf.req = 2'b00;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that shares one 32x32 -> 64-bit multiplier between two requesters. It latches a granted requester's operands and drives them to the multiplier for a fixed latency. It then captures the 64-bit product and returns it to the owning requester with a one-cycle done pulse. It sits between the MMIO slot cores and the single multiplier instance in the ALU subsystem.

## Interface
Parameters:
- MUL_LAT, default 3: cycles the multiplier needs from stable operands to valid product; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  2  request per requester (bit 0 = requester 0); held high until ack
- a0, b0  in  32 each  requester 0 operands; must be valid while req[0] is high
- a1, b1  in  32 each  requester 1 operands; must be valid while req[1] is high
- ack  out  2  one-hot, one-cycle accept pulse; operands are sampled on this cycle's edge
- done  out  2  one-hot, one-cycle completion pulse to the owning requester
- result  out  64  product of the last completed operation; held until the next completion
- busy  out  1  high whenever state is not IDLE
- mul_a, mul_b  out  32 each  operands to the shared multiplier; stable for the whole BUSY phase
- mul_prod  in  64  multiplier output

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise grant one requester. ack[g] is high this cycle.
  - On the edge, latch the granted requester's a and b into the operand registers, latch owner = g, load cnt = MUL_LAT-1, and go to BUSY.
- Arbitration:
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - ack is combinational from req, state and the pointer. It is never asserted outside IDLE.
- BUSY:
  - mul_a and mul_b are driven from the operand registers.
  - cnt decrements every cycle.
  - When cnt == 0, capture mul_prod into result on that edge and go to DONE.
- DONE:
  - done[owner] = 1 for exactly one cycle, and result is valid.
  - Update the last-served pointer to owner, then go to IDLE.
- No request is accepted in BUSY or DONE. Pending req simply waits.
- Dropping req before ack withdraws the request. Dropping req after ack has no effect.
- mul_a and mul_b keep their last values in IDLE and DONE.

## Timing
- Reset values: state IDLE; ack 0, done 0, busy 0; result 0; mul_a 0, mul_b 0; cnt 0; pointer 1.
- Reset asserted mid-operation aborts it:
  - no done pulse;
  - the in-flight product is discarded;
  - the pointer returns to 1.
- Latency and throughput:
  - Request accepted in cycle k (ack high).
  - BUSY during cycles k+1 .. k+MUL_LAT.
  - done and the new result first visible in cycle k+MUL_LAT+1.
  - Earliest next ack in cycle k+MUL_LAT+2.
  - Throughput is one operation per MUL_LAT+2 cycles.
- busy is high in cycles k+1 .. k+MUL_LAT+1.
- Simultaneous req in the same cycle resolves by the pointer only. There is no fixed priority after the first operation.
- Unsigned arithmetic: result = a × b as a full 64-bit product, with no truncation. 0xFFFFFFFF × 0xFFFFFFFF = 0xFFFFFFFE_00000001.

## Configuration
- MULT_SCHED_SIGNED_EN defined: operands are two's-complement.
  - At accept, the operand registers latch |a| and |b|, with |−2^31| = 0x80000000 as an unsigned value.
  - A neg flag latches sign(a) XOR sign(b).
  - At capture, result = neg ? −mul_prod : mul_prod, in 64-bit two's-complement.
  - The multiplier always sees unsigned magnitudes. Latency is unchanged.
- Undefined: purely unsigned. No neg flag or negation logic exists.

## Test plan
- Single request: reset, then req[0] with a0=7, b0=6 at MUL_LAT=3.
  - ack[0] in cycle k, done[0] in cycle k+4, result=42.
  - busy high for 4 cycles.
- Tie: req=2'b11 with a0=3, b0=5, a1=0xFFFFFFFF, b1=0xFFFFFFFF, held.
  - Requester 0 served first: result=15.
  - Requester 1 acked in cycle k+5: result=0xFFFFFFFE00000001.
  - A third tie goes to requester 0.
- Back-pressure: req[1] raised while BUSY for requester 0.
  - No ack[1] until IDLE.
  - a1 and b1 changed during the wait; the values present at ack are the ones used.
- Reset mid-BUSY: assert reset one cycle after ack.
  - No done pulse; result=0; busy=0 next cycle.
  - The next tie is granted to requester 0.
- Signed, with MULT_SCHED_SIGNED_EN:
  - a=0xFFFFFFFE (−2), b=3 -> 0xFFFFFFFFFFFFFFFA.
  - a=0x80000000, b=0x80000000 -> 0x4000000000000000.
  - Unsigned build, same first operands -> 0x00000002FFFFFFFA.
